// File: rtl/team_06_echo_pkg.sv
// Shared types and constants for the echo delay-line controller.
package team_06_echo_pkg;

    // Transaction sequencer states: write the new sample, optionally read the delayed one.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } echo_state_t;

    localparam int SAMPLE_W      = 8;
    localparam int ECHO_OFFSET_W = 13;
    localparam int DEFAULT_DEPTH = 8192;

endpackage

// File: rtl/team_06_echo_addr_gen.sv
// Circular-buffer address generator: write pointer, fill level, clamped
// offset and the wrapped read address for the echo delay line.
module team_06_echo_addr_gen
    import team_06_echo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int FW   = AW + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_i,     // capture offset for a new transaction
    input  logic [ECHO_OFFSET_W-1:0] offset_i,
    input  logic                     wr_done_i,  // write acknowledged: advance pointers
    output logic [AW-1:0]            wr_ptr_o,
    output logic [AW-1:0]            rd_addr_o,  // entry written off_q samples before wr_ptr
    output logic                     rd_ok_o     // delayed sample exists after this write
);

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] off_q;
    logic [AW-1:0] off_d;
    logic [FW-1:0] fill_q;
    logic [FW-1:0] fill_d;

    // Clamp the requested delay to the buffer length and compute the saturated fill level.
    always_comb begin
        off_d = AW'(offset_i);
        if (32'(offset_i) >= DEPTH) begin
            off_d = AW'(DEPTH - 1);
        end
        fill_d = (fill_q == FW'(DEPTH)) ? fill_q : fill_q + 1'b1;
    end

    // The subtraction is done in AW bits so that it wraps modulo DEPTH for free.
    assign rd_addr_o = wr_ptr_q - off_q;
    assign rd_ok_o   = ({1'b0, off_q} < fill_d);
    assign wr_ptr_o  = wr_ptr_q;

    // Pointer, fill level and latched offset registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            off_q    <= '0;
            fill_q   <= '0;
        end else begin
            if (load_i) begin
                off_q <= off_d;
            end
            if (wr_done_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                fill_q   <= fill_d;
            end
        end
    end

endmodule

// File: rtl/team_06_echo_delay_buffer.sv
// Echo delay-line controller: stores each sample into an SRAM circular
// buffer and returns the sample captured OFFSET samples earlier.
// Optional ack watchdog and mem_err output enabled by ECHO_BUF_TIMEOUT_EN.
// Handshake: mem_req rises with mem_we/mem_addr/mem_wdata stable and is held
// until a cycle where mem_ack is high; that cycle completes the access.
module team_06_echo_delay_buffer
    import team_06_echo_pkg::*;
#(
    parameter int                DEPTH     = DEFAULT_DEPTH,
    parameter int                DATA_W    = SAMPLE_W,
    parameter int                MEM_AW    = 16,
    parameter logic [MEM_AW-1:0] BASE_ADDR = '0,
    parameter int                TIMEOUT   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_strobe,
    input  logic [DATA_W-1:0]        save_audio,
    input  logic [ECHO_OFFSET_W-1:0] offset,
    input  logic                     search,
    output logic [DATA_W-1:0]        past_output,
    output logic                     past_valid,
    output logic                     busy,
    output logic                     overrun,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [MEM_AW-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ack
`ifdef ECHO_BUF_TIMEOUT_EN
    ,
    output logic                     mem_err
`endif
);

    localparam int AW = $clog2(DEPTH);

    echo_state_t       state_q;
    logic              search_q;
    logic [DATA_W-1:0] past_output_q;
    logic              past_valid_q;
    logic              overrun_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_addr;
    logic              rd_ok;
    logic              load;
    logic              wr_done;

    assign load    = (state_q == IDLE) && sample_strobe;
    assign wr_done = (state_q == WR) && mem_req_q && mem_ack;

    team_06_echo_addr_gen #(
        .DEPTH (DEPTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .offset_i  (offset),
        .wr_done_i (wr_done),
        .wr_ptr_o  (wr_ptr),
        .rd_addr_o (rd_addr),
        .rd_ok_o   (rd_ok)
    );

`ifdef ECHO_BUF_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_q;
    logic           mem_err_q;
    logic           wd_expired;
    assign wd_expired = (wd_q == WDW'(TIMEOUT - 1));
    assign mem_err    = mem_err_q;
`endif

    // Sequencer: write the sample, optionally read the delayed entry, then publish the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            search_q      <= 1'b0;
            past_output_q <= '0;
            past_valid_q  <= 1'b0;
            overrun_q     <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
`ifdef ECHO_BUF_TIMEOUT_EN
            wd_q          <= '0;
            mem_err_q     <= 1'b0;
`endif
        end else begin
            past_valid_q <= 1'b0;
            // Any strobe outside IDLE (including the DONE cycle) is dropped.
            if (sample_strobe && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (sample_strobe) begin
                        search_q    <= search;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= BASE_ADDR + MEM_AW'(wr_ptr);
                        mem_wdata_q <= save_audio;
                        state_q     <= WR;
`ifdef ECHO_BUF_TIMEOUT_EN
                        wd_q        <= '0;
`endif
                    end
                end
                WR: begin
                    if (mem_ack) begin
                        if (search_q && rd_ok) begin
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= BASE_ADDR + MEM_AW'(rd_addr);
                            state_q    <= RD;
`ifdef ECHO_BUF_TIMEOUT_EN
                            wd_q       <= '0;
`endif
                        end else begin
                            // Delay reaches past the filled part of the buffer: emit silence.
                            mem_req_q     <= 1'b0;
                            mem_we_q      <= 1'b0;
                            past_output_q <= '0;
                            past_valid_q  <= 1'b1;
                            state_q       <= DONE;
                        end
                    end
`ifdef ECHO_BUF_TIMEOUT_EN
                    else if (wd_expired) begin
                        mem_req_q     <= 1'b0;
                        mem_we_q      <= 1'b0;
                        past_output_q <= '0;
                        past_valid_q  <= 1'b1;
                        mem_err_q     <= 1'b1;
                        state_q       <= DONE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end
                RD: begin
                    if (mem_ack) begin
                        mem_req_q     <= 1'b0;
                        past_output_q <= mem_rdata;
                        past_valid_q  <= 1'b1;
                        state_q       <= DONE;
                    end
`ifdef ECHO_BUF_TIMEOUT_EN
                    else if (wd_expired) begin
                        mem_req_q     <= 1'b0;
                        past_output_q <= '0;
                        past_valid_q  <= 1'b1;
                        mem_err_q     <= 1'b1;
                        state_q       <= DONE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign past_output = past_output_q;
    assign past_valid  = past_valid_q;
    assign busy        = (state_q != IDLE);
    assign overrun     = overrun_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_team_06_echo_delay_buffer.sv
// Bench for team_06_echo_delay_buffer built with DEPTH=16, BASE_ADDR=0x0100,
// TIMEOUT=8 against a behavioural SRAM with programmable ack delay.
module tb_team_06_echo_delay_buffer;

    localparam int          DEPTH   = 16;
    localparam int          DATA_W  = 8;
    localparam int          MEM_AW  = 16;
    localparam logic [15:0] BASE    = 16'h0100;
    localparam int          TIMEOUT = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic              sample_strobe = 1'b0;
    logic [7:0]        save_audio = '0;
    logic [12:0]       offset = '0;
    logic              search = 1'b0;
    logic [7:0]        past_output;
    logic              past_valid;
    logic              busy;
    logic              overrun;
    logic              mem_req;
    logic              mem_we;
    logic [15:0]       mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;
`ifdef ECHO_BUF_TIMEOUT_EN
    logic              mem_err;
`endif

    team_06_echo_delay_buffer #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .MEM_AW(MEM_AW), .BASE_ADDR(BASE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .sample_strobe(sample_strobe), .save_audio(save_audio),
        .offset(offset), .search(search), .past_output(past_output), .past_valid(past_valid),
        .busy(busy), .overrun(overrun), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef ECHO_BUF_TIMEOUT_EN
        , .mem_err(mem_err)
`endif
    );

    // ---------------- SRAM model ----------------
    logic [7:0]  sram [0:65535];
    int          ack_delay = 0;
    logic        ack_en = 1'b1;
    int          wait_cnt = 0;
    int          wr_count = 0;
    logic [15:0] last_wr_addr = '0;
    logic [15:0] last_rd_addr = '0;
    logic [7:0]  last_wr_data = '0;

    assign mem_ack   = mem_req && ack_en && (wait_cnt >= ack_delay);
    assign mem_rdata = sram[mem_addr];

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (mem_req && mem_ack) begin
            if (mem_we) begin
                sram[mem_addr] <= mem_wdata;
                last_wr_addr   <= mem_addr;
                last_wr_data   <= mem_wdata;
                wr_count       <= wr_count + 1;
            end else begin
                last_rd_addr <= mem_addr;
            end
        end
    end

    // Request monitor: cycles with mem_req high, and drops of mem_req without an ack.
    int   req_cycles = 0;
    int   req_drops = 0;
    logic prev_req = 1'b0;
    logic prev_ack = 1'b0;
    always @(negedge clk) begin
        if (mem_req) req_cycles <= req_cycles + 1;
        if (prev_req && !prev_ack && !mem_req && !rst) req_drops <= req_drops + 1;
        prev_req <= mem_req;
        prev_ack <= mem_ack;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        sample_strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_strobe(input logic [7:0] s, input logic [12:0] off, input logic srch,
                             output logic [7:0] out, output int lat, output bit ok);
        int t0;
        @(posedge clk); #1;
        sample_strobe = 1'b1; save_audio = s; offset = off; search = srch;
        t0 = cyc;
        @(posedge clk); #1;
        sample_strobe = 1'b0;
        ok = 1'b0; out = '0; lat = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (past_valid) begin
                out = past_output; lat = cyc - t0; ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vec(input string name, input logic [7:0] s, input logic [12:0] off,
                           input logic srch, input logic [7:0] exp_out, input int exp_lat);
        logic [7:0] out;
        int lat;
        bit ok;
        do_strobe(s, off, srch, out, lat, ok);
        check({name, "_valid_seen"}, 32'(ok), 32'd1);
        check({name, "_out"}, 32'(out), 32'(exp_out));
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    typedef struct {
        logic [7:0]  sample;
        logic [12:0] offset;
        logic        search;
        logic [7:0]  exp_out;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0] out;
        int lat;
        bit ok;
        int rc0, rd0, wc0;
        bit found;

        // Offset 3 over the first five samples, then offset 0, a full-depth hit, and no-search.
        vecs[0] = '{8'd10,   13'd3, 1'b1, 8'd0,    2};
        vecs[1] = '{8'd20,   13'd3, 1'b1, 8'd0,    2};
        vecs[2] = '{8'd30,   13'd3, 1'b1, 8'd0,    2};
        vecs[3] = '{8'd40,   13'd3, 1'b1, 8'd10,   3};
        vecs[4] = '{8'd50,   13'd3, 1'b1, 8'd20,   3};
        vecs[5] = '{8'h5A,   13'd0, 1'b1, 8'h5A,   3};
        vecs[6] = '{8'h66,   13'd6, 1'b1, 8'd10,   3};
        vecs[7] = '{8'h77,   13'd2, 1'b0, 8'd0,    2};

        do_reset();
        @(negedge clk);
        check("rst_past_output", 32'(past_output), 32'd0);
        check("rst_past_valid",  32'(past_valid),  32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_overrun",     32'(overrun),     32'd0);
        check("rst_mem_req",     32'(mem_req),     32'd0);
        check("rst_mem_we",      32'(mem_we),      32'd0);
        check("rst_mem_addr",    32'(mem_addr),    32'd0);
        check("rst_mem_wdata",   32'(mem_wdata),   32'd0);
`ifdef ECHO_BUF_TIMEOUT_EN
        check("rst_mem_err",     32'(mem_err),     32'd0);
`endif

        // Table: zero-wait SRAM.
        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].sample, vecs[i].offset, vecs[i].search,
                    vecs[i].exp_out, vecs[i].exp_lat);
            check($sformatf("vec%0d_wr_addr", i), 32'(last_wr_addr), 32'(BASE + 16'(i)));
            if (i == 5) check("off0_same_addr", 32'(last_rd_addr), 32'(last_wr_addr));
        end
        check("table_no_overrun", 32'(overrun), 32'd0);

        // Wrap: 20 samples into a 16-entry buffer, then clamped offsets.
        do_reset();
        for (int k = 1; k <= 19; k++) begin
            run_vec($sformatf("wrap%0d", k), 8'(k), 13'd0, 1'b0, 8'd0, 2);
            check($sformatf("wrap%0d_wr_addr", k), 32'(last_wr_addr), 32'(BASE + 16'((k - 1) % 16)));
        end
        run_vec("wrap20", 8'd20, 13'd15, 1'b1, 8'd5, 3);
        check("wrap20_wr_addr", 32'(last_wr_addr), 32'(BASE + 16'd3));
        check("wrap20_rd_addr", 32'(last_rd_addr), 32'(BASE + 16'd4));
        run_vec("clamp100", 8'd21, 13'd100, 1'b1, 8'd6, 3);
        check("clamp100_rd_addr", 32'(last_rd_addr), 32'(BASE + 16'd5));
        run_vec("clamp16", 8'd22, 13'd16, 1'b1, 8'd7, 3);

        // Slow SRAM, second strobe while busy.
        do_reset();
        ack_delay = 4;
        @(posedge clk);
        rc0 = req_cycles; rd0 = req_drops; wc0 = wr_count;
        #1 sample_strobe = 1'b1; save_audio = 8'h11; offset = 13'd0; search = 1'b1;
        @(posedge clk); #1 save_audio = 8'h22;
        @(posedge clk); #1 sample_strobe = 1'b0;
        ok = 1'b0; out = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (past_valid) begin ok = 1'b1; out = past_output; break; end
        end
        @(posedge clk); #1;
        check("slow_valid_seen", 32'(ok), 32'd1);
        check("slow_out", 32'(out), 32'h11);
        check("slow_overrun", 32'(overrun), 32'd1);
        check("slow_req_cycles", 32'(req_cycles - rc0), 32'd10);
        check("slow_req_drops", 32'(req_drops - rd0), 32'd0);
        check("slow_wr_count", 32'(wr_count - wc0), 32'd1);
        check("slow_wr_data", 32'(last_wr_data), 32'h11);
        ack_delay = 0;
        run_vec("after_slow", 8'h23, 13'd0, 1'b1, 8'h23, 3);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Reset while a read is waiting.
        do_reset();
        ack_delay = 0;
        run_vec("rstrd_pre", 8'h33, 13'd0, 1'b1, 8'h33, 3);
        ack_delay = 3;
        @(posedge clk); #1 sample_strobe = 1'b1; save_audio = 8'h55; offset = 13'd0; search = 1'b1;
        @(posedge clk); #1 sample_strobe = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req && !mem_we) begin found = 1'b1; break; end
        end
        check("rstrd_in_read", 32'(found), 32'd1);
        rst = 1'b1;
        #1 check("rstrd_req_async", 32'(mem_req), 32'd0);
        @(negedge clk);
        check("rstrd_req", 32'(mem_req), 32'd0);
        check("rstrd_busy", 32'(busy), 32'd0);
        check("rstrd_past_output", 32'(past_output), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        ack_delay = 0;
        run_vec("rstrd_post_fill", 8'h44, 13'd1, 1'b1, 8'd0, 2);
        check("rstrd_post_wr_addr", 32'(last_wr_addr), 32'(BASE));
        check("rstrd_post_wr_data", 32'(last_wr_data), 32'h44);

`ifdef ECHO_BUF_TIMEOUT_EN
        // Ack never arrives: watchdog abandons the write.
        do_reset();
        ack_delay = 0; ack_en = 1'b1;
        run_vec("to_pre", 8'h12, 13'd0, 1'b1, 8'h12, 3);
        @(posedge clk);
        rc0 = req_cycles; rd0 = req_drops;
        ack_en = 1'b0;
        run_vec("to_hang", 8'h99, 13'd0, 1'b1, 8'd0, 9);
        @(posedge clk); #1;
        check("to_req_cycles", 32'(req_cycles - rc0), 32'd8);
        check("to_req_drops", 32'(req_drops - rd0), 32'd1);
        check("to_mem_err", 32'(mem_err), 32'd1);
        ack_en = 1'b1;
        run_vec("to_post", 8'hAB, 13'd0, 1'b1, 8'hAB, 3);
        check("to_post_wr_addr", 32'(last_wr_addr), 32'(BASE + 16'd1));
        check("to_mem_err_sticky", 32'(mem_err), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
